// File: rtl/rv32_pkg.sv
// Shared RV32I encodings: ALU ops, forwarding selects and branch funct3 codes.
// Used by the execute stage and its ALU.
package rv32_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Resolve a branch condition from the two forwarded operands.
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage bundle: ID/EX inputs, forwarding selects, redirect and EX/MEM outputs.
// slave is the stage itself; master is whatever drives the E-side and observes M.
interface execute_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RD_E;
  logic [3:0]      ALUControlE;
  logic [2:0]      Funct3E;
  logic            ALUSrcE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            BranchE;
  logic            JumpE;
  logic            JalrE;
  logic [1:0]      ResultSrcE;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport slave (
    input  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ALUControlE, Funct3E,
           ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ResultSrcE,
           ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport master (
    output RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ALUControlE, Funct3E,
           ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ResultSrcE,
           ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALUResultM, WriteDataM, PCPlus4M
  );

endinterface

// File: rtl/execute_stage_alu.sv
// RV32I ALU, purely combinational; unknown op codes yield zero.
// Shifts use only the low five bits of SrcB.
module alu
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [3:0]      ALUControl,
  output logic [XLEN-1:0] Result
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = SrcB[4:0];
  assign lt_s  = $signed(SrcA) < $signed(SrcB);
  assign lt_u  = SrcA < SrcB;

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD:   Result = SrcA + SrcB;
      ALU_SUB:   Result = SrcA - SrcB;
      ALU_AND:   Result = SrcA & SrcB;
      ALU_OR:    Result = SrcA | SrcB;
      ALU_XOR:   Result = SrcA ^ SrcB;
      ALU_SLL:   Result = SrcA << shamt;
      ALU_SRL:   Result = SrcA >> shamt;
      ALU_SRA:   Result = $unsigned($signed(SrcA) >>> shamt);
      ALU_SLT:   Result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:  Result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_PASSB: Result = SrcB;
      default:   Result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolve and the EX/MEM register.
// Redirect is combinational; M outputs have one cycle of latency; no stall or flush.
module execute_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave bus
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] jalr_sum;
  logic            cond;

  always_comb begin
    src_a = bus.RD1_E;
    case (bus.ForwardAE)
      FWD_WB:  src_a = bus.ResultW;
      FWD_MEM: src_a = bus.ALUResultM;
      default: src_a = bus.RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = bus.RD2_E;
    case (bus.ForwardBE)
      FWD_WB:  fwd_b = bus.ResultW;
      FWD_MEM: fwd_b = bus.ALUResultM;
      default: fwd_b = bus.RD2_E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (bus.ALUControlE),
    .Result     (alu_result)
  );

  // Branches compare the forwarded register operands, never SrcB, so an
  // immediate on the B side cannot leak into the decision.
  assign cond = branch_taken(bus.Funct3E, src_a == fwd_b,
                             $signed(src_a) < $signed(fwd_b), src_a < fwd_b);

  assign jalr_sum      = src_a + bus.Imm_Ext_E;
  assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & cond);
  assign bus.PCTargetE = bus.JalrE ? {jalr_sum[XLEN-1:1], 1'b0}
                                   : bus.PCE + bus.Imm_Ext_E;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= '0;
      bus.RD_M       <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.PCPlus4M   <= '0;
    end else begin
      bus.RegWriteM  <= bus.RegWriteE;
      bus.MemWriteM  <= bus.MemWriteE;
      bus.ResultSrcM <= bus.ResultSrcE;
      bus.RD_M       <= bus.RD_E;
      bus.ALUResultM <= alu_result;
      bus.WriteDataM <= fwd_b;
      bus.PCPlus4M   <= bus.PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized checks of execute_stage against a behavioural model.
module tb_execute_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  execute_stage_if #(.XLEN(32)) ex ();

  execute_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ex)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] d;
    int          s;
    s = int'(b[4:0]);
    d = 32'd1 << s;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  begin p = {32'd0, a} * {32'd0, d}; return p[31:0]; end
      4'd6:  return a / d;
      4'd7:  return a[31] ? ~((~a) / d) : a / d;
      4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_branch(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] wb, input logic [31:0] mem);
    return (sel == 2'b01) ? wb : (sel == 2'b10) ? mem : rf;
  endfunction

  task automatic drive_nop();
    ex.RD1_E = '0; ex.RD2_E = '0; ex.Imm_Ext_E = '0; ex.PCE = '0; ex.PCPlus4E = '0;
    ex.RD_E = '0; ex.ALUControlE = '0; ex.Funct3E = '0; ex.ALUSrcE = 1'b0;
    ex.RegWriteE = 1'b0; ex.MemWriteE = 1'b0; ex.BranchE = 1'b0; ex.JumpE = 1'b0;
    ex.JalrE = 1'b0; ex.ResultSrcE = '0; ex.ForwardAE = '0; ex.ForwardBE = '0;
    ex.ResultW = '0;
  endtask

  function automatic logic [104:0] m_bus();
    return {ex.RegWriteM, ex.MemWriteM, ex.ResultSrcM, ex.RD_M,
            ex.ALUResultM, ex.WriteDataM, ex.PCPlus4M};
  endfunction

  task automatic test_reset();
    drive_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (m_bus() !== '0) begin
      n_err++; $display("FAIL reset_state got %h want 0", m_bus());
    end
    rst = 1'b0;
    ex.RD1_E = 32'h1234; ex.ALUSrcE = 1'b1; ex.ALUControlE = 4'd0;
    ex.RegWriteE = 1'b1; ex.MemWriteE = 1'b1; ex.RD_E = 5'd7; ex.PCPlus4E = 32'h44;
    @(posedge clk); #1;
    n_vec++;
    if (ex.ALUResultM !== 32'h1234) begin
      n_err++; $display("FAIL preload ALUResultM got %h want 00001234", ex.ALUResultM);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (m_bus() !== '0) begin
      n_err++; $display("FAIL async_reset got %h want 0", m_bus());
    end
    @(negedge clk);
    rst = 1'b0;
    drive_nop();
    ex.RD1_E = 32'd5; ex.RD2_E = 32'd7; ex.ALUControlE = 4'd0;
    @(posedge clk); #1;
    n_vec++;
    if (ex.ALUResultM !== 32'd12) begin
      n_err++; $display("FAIL post_reset_add got %h want 0000000c", ex.ALUResultM);
    end
  endtask

  task automatic test_forwarding();
    logic [1:0]  sel [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] exp [3] = '{32'h11, 32'h21, 32'h2};
    @(negedge clk);
    drive_nop();
    ex.RD1_E = 32'h10; ex.ALUSrcE = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex.RD1_E = 32'd1; ex.ResultW = 32'h20; ex.Imm_Ext_E = 32'd1;
      ex.ALUSrcE = 1'b1; ex.ForwardAE = sel[i];
      @(posedge clk); #1;
      n_vec++;
      if (ex.ALUResultM !== exp[i]) begin
        n_err++; $display("FAIL fwd_a sel=%b got %h want %h", sel[i], ex.ALUResultM, exp[i]);
      end
    end
  endtask

  task automatic test_store_forward();
    @(negedge clk);
    drive_nop();
    ex.RD1_E = 32'h2000; ex.Imm_Ext_E = 32'h8; ex.ALUSrcE = 1'b1; ex.MemWriteE = 1'b1;
    ex.RD2_E = 32'h55; ex.ForwardBE = 2'b01; ex.ResultW = 32'hDEADBEEF;
    @(posedge clk); #1;
    n_vec++;
    if (ex.WriteDataM !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL store_wdata got %h want deadbeef", ex.WriteDataM);
    end
    n_vec++;
    if (ex.ALUResultM !== 32'h2008 || ex.MemWriteM !== 1'b1) begin
      n_err++; $display("FAIL store_addr got %h/%b want 00002008/1", ex.ALUResultM, ex.MemWriteM);
    end
  endtask

  task automatic test_branches();
    logic [2:0] f3  [3] = '{3'b100, 3'b110, 3'b010};
    logic       exp [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_nop();
      ex.RD1_E = 32'hFFFFFFFF; ex.RD2_E = 32'd1; ex.BranchE = 1'b1; ex.Funct3E = f3[i];
      ex.PCE = 32'h100; ex.Imm_Ext_E = 32'h20; ex.ALUSrcE = 1'b1;
      #1;
      n_vec++;
      if (ex.PCSrcE !== exp[i]) begin
        n_err++; $display("FAIL branch f3=%b PCSrcE got %b want %b", f3[i], ex.PCSrcE, exp[i]);
      end
      n_vec++;
      if (ex.PCTargetE !== 32'h120) begin
        n_err++; $display("FAIL branch_target got %h want 00000120", ex.PCTargetE);
      end
    end
  endtask

  task automatic test_jalr();
    @(negedge clk);
    drive_nop();
    ex.ForwardAE = 2'b01; ex.ResultW = 32'h1003; ex.RD1_E = 32'h7777;
    ex.Imm_Ext_E = 32'd4; ex.JumpE = 1'b1; ex.JalrE = 1'b1; ex.PCE = 32'h500;
    ex.PCPlus4E = 32'h504; ex.RegWriteE = 1'b1; ex.RD_E = 5'd1;
    #1;
    n_vec++;
    if (ex.PCTargetE !== 32'h1006 || ex.PCSrcE !== 1'b1) begin
      n_err++; $display("FAIL jalr got %h/%b want 00001006/1", ex.PCTargetE, ex.PCSrcE);
    end
    @(posedge clk); #1;
    n_vec++;
    if (ex.PCPlus4M !== 32'h504 || ex.RD_M !== 5'd1 || ex.RegWriteM !== 1'b1) begin
      n_err++; $display("FAIL jalr_link got %h/%0d/%b want 00000504/1/1",
                        ex.PCPlus4M, ex.RD_M, ex.RegWriteM);
    end
  endtask

  task automatic test_alu_corners();
    logic [3:0]  op  [4] = '{4'b0111, 4'b0001, 4'b0101, 4'b1111};
    logic [31:0] a   [4] = '{32'h80000000, 32'd0, 32'd1, 32'd5};
    logic [31:0] b   [4] = '{32'd31, 32'd1, 32'd33, 32'd3};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_nop();
      ex.RD1_E = a[i]; ex.Imm_Ext_E = b[i]; ex.ALUSrcE = 1'b1; ex.ALUControlE = op[i];
      @(posedge clk); #1;
      n_vec++;
      if (ex.ALUResultM !== exp[i]) begin
        n_err++; $display("FAIL alu_corner op=%b got %h want %h", op[i], ex.ALUResultM, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0]  m_alu, fa, fb, sb, tgt, res;
    logic         take;
    logic [104:0] exp_m;
    @(negedge clk);
    rst = 1'b1;
    drive_nop();
    #1 rst = 1'b0;
    m_alu = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ex.RD1_E = $urandom; ex.RD2_E = $urandom; ex.ResultW = $urandom;
      ex.Imm_Ext_E = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 40);
      ex.PCE = $urandom; ex.PCPlus4E = $urandom; ex.RD_E = 5'($urandom);
      ex.ALUControlE = 4'($urandom); ex.Funct3E = 3'($urandom); ex.ALUSrcE = 1'($urandom);
      ex.RegWriteE = 1'($urandom); ex.MemWriteE = 1'($urandom); ex.BranchE = 1'($urandom);
      ex.JumpE = 1'($urandom); ex.JalrE = 1'($urandom); ex.ResultSrcE = 2'($urandom);
      ex.ForwardAE = 2'($urandom); ex.ForwardBE = 2'($urandom);
      if ($urandom_range(0, 3) == 0) ex.RD2_E = ex.RD1_E;
      fa   = ref_fwd(ex.ForwardAE, ex.RD1_E, ex.ResultW, m_alu);
      fb   = ref_fwd(ex.ForwardBE, ex.RD2_E, ex.ResultW, m_alu);
      sb   = ex.ALUSrcE ? ex.Imm_Ext_E : fb;
      res  = ref_alu(ex.ALUControlE, fa, sb);
      take = ex.JumpE || (ex.BranchE && ref_branch(ex.Funct3E, fa, fb));
      tgt  = ex.JalrE ? ((fa + ex.Imm_Ext_E) & 32'hFFFFFFFE) : (ex.PCE + ex.Imm_Ext_E);
      exp_m = {ex.RegWriteE, ex.MemWriteE, ex.ResultSrcE, ex.RD_E, res, fb, ex.PCPlus4E};
      #1;
      n_vec++;
      if (ex.PCSrcE !== take || ex.PCTargetE !== tgt) begin
        n_err++; $display("FAIL rand_redirect i=%0d got %b/%h want %b/%h",
                          i, ex.PCSrcE, ex.PCTargetE, take, tgt);
      end
      @(posedge clk); #1;
      n_vec++;
      if (m_bus() !== exp_m) begin
        n_err++; $display("FAIL rand_mreg i=%0d op=%h got %h want %h",
                          i, ex.ALUControlE, m_bus(), exp_m);
      end
      m_alu = res;
    end
  endtask

  initial begin
    drive_nop();
    test_reset();
    test_forwarding();
    test_store_forward();
    test_branches();
    test_jalr();
    test_alu_corners();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
